jsv_key_param_ctrl: RTL and testbench

// Consumes the 8-bit USB HID keycode exported by the jsv SoC (keycode_export) and turns
// key presses into Julia-set view parameters: constant c (re/im), pan (x/y), zoom.

---
 rtl/jsv_pkg.sv | 37 +++
 rtl/jsv_sat_addsub.sv | 28 ++
 rtl/jsv_key_param_ctrl.sv | 153 +++++++++++++++
 tb/tb_jsv_key_param_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jsv_pkg.sv
// Shared constants for the jsv keyboard-driven Julia-set parameter controller:
// HID usages, Q4.12 defaults, saturation limits and the key FSM state type.
package jsv_pkg;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_E     = 8'h08;
    localparam logic [7:0] KEY_Q     = 8'h14;
    localparam logic [7:0] KEY_R     = 8'h15;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    localparam logic signed [15:0] C_RE_DEF = 16'shF334;
    localparam logic signed [15:0] C_IM_DEF = 16'sh027F;
    localparam logic signed [15:0] C_LIM    = 16'sh2000;
    localparam logic signed [15:0] PAN_LIM  = 16'sh4000;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HOLD} state_e;

    function automatic logic key_mapped(input logic [7:0] k);
        case (k)
            KEY_A, KEY_D, KEY_E, KEY_Q, KEY_R, KEY_S, KEY_W,
            KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Restore is a one-shot action; holding it must not keep resetting the view.
    function automatic logic key_repeats(input logic [7:0] k);
        return key_mapped(k) && (k != KEY_R);
    endfunction

endpackage

// File: rtl/jsv_sat_addsub.sv
// Signed add/subtract of an unsigned step magnitude, clamped symmetrically to +/-LIM.
module jsv_sat_addsub #(
    parameter int                    W   = 16,
    parameter logic signed [W-1:0]   LIM = 16'sh2000
) (
    input  logic signed [W-1:0] a_i,
    input  logic        [W-1:0] step_i,
    input  logic                sub_i,
    output logic signed [W-1:0] y_o
);

    logic signed [W+1:0] a_x, s_x, lim_x, sum;

    assign a_x   = {{2{a_i[W-1]}}, a_i};
    assign s_x   = {2'b00, step_i};
    assign lim_x = {{2{LIM[W-1]}}, LIM};

    always_comb begin
        sum = sub_i ? (a_x - s_x) : (a_x + s_x);
        if (sum > lim_x)
            y_o = LIM;
        else if (sum < -lim_x)
            y_o = -LIM;
        else
            y_o = sum[W-1:0];
    end

endmodule

// File: rtl/jsv_key_param_ctrl.sv
// Turns HID keycodes into Julia-set view parameters with press/auto-repeat and
// publishes a frozen snapshot to the render engine through a valid/ack handshake.
module jsv_key_param_ctrl
    import jsv_pkg::*;
#(
    parameter int W             = 16,
    parameter int C_STEP        = 16,
    parameter int PAN_BASE      = 'h0400,
    parameter int ZOOM_MAX      = 10,
    parameter int REPEAT_FRAMES = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [7:0]          keycode,
    input  logic                frame_start,
    output logic signed [W-1:0] c_re,
    output logic signed [W-1:0] c_im,
    output logic signed [W-1:0] pan_x,
    output logic signed [W-1:0] pan_y,
    output logic [3:0]          zoom,
    output logic                param_valid,
    input  logic                param_ack,
    output logic                key_active
);

    localparam int              CNT_W      = $clog2(REPEAT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REPEAT_FRAMES - 1);
    localparam logic [W-1:0]    C_STEP_W   = W'(C_STEP);
    localparam logic [W-1:0]    PAN_BASE_W = W'(PAN_BASE);
    localparam logic [3:0]      ZOOM_MAX_W = 4'(ZOOM_MAX);

    state_e           state_q;
    logic [7:0]       key_q, held_q;
    logic [CNT_W-1:0] cnt_q;
    logic             key_active_q, valid_q, step;

    logic signed [W-1:0] wc_re_q, wc_im_q, wpan_x_q, wpan_y_q;
    logic signed [W-1:0] pc_re_q, pc_im_q, ppan_x_q, ppan_y_q;
    logic [3:0]          wzoom_q, pzoom_q;
    logic signed [W-1:0] wc_re_d, wc_im_d, wpan_x_d, wpan_y_d;
    logic [W-1:0]        pan_shift, pan_step;

    // One step per PRESS, plus one every REPEAT_FRAMES frames while the same key is held.
    assign step = (state_q == ST_PRESS) ||
                  ((state_q == ST_HOLD) && (key_q == held_q) && frame_start &&
                   (cnt_q == CNT_LAST) && key_repeats(held_q));

    assign pan_shift = PAN_BASE_W >> wzoom_q;
    assign pan_step  = (pan_shift == '0) ? W'(1) : pan_shift;

    jsv_sat_addsub #(.W(W), .LIM(W'(C_LIM))) u_c_re (
        .a_i(wc_re_q), .step_i(C_STEP_W), .sub_i(held_q == KEY_LEFT), .y_o(wc_re_d));
    jsv_sat_addsub #(.W(W), .LIM(W'(C_LIM))) u_c_im (
        .a_i(wc_im_q), .step_i(C_STEP_W), .sub_i(held_q == KEY_DOWN), .y_o(wc_im_d));
    jsv_sat_addsub #(.W(W), .LIM(W'(PAN_LIM))) u_pan_x (
        .a_i(wpan_x_q), .step_i(pan_step), .sub_i(held_q == KEY_A), .y_o(wpan_x_d));
    jsv_sat_addsub #(.W(W), .LIM(W'(PAN_LIM))) u_pan_y (
        .a_i(wpan_y_q), .step_i(pan_step), .sub_i(held_q == KEY_S), .y_o(wpan_y_d));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_q        <= '0;
            held_q       <= '0;
            cnt_q        <= '0;
            key_active_q <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            key_q <= keycode;
            case (state_q)
                ST_IDLE: if (key_q != '0) begin
                    state_q      <= ST_PRESS;
                    held_q       <= key_q;
                    key_active_q <= key_mapped(key_q);
                end
                ST_PRESS: begin
                    cnt_q   <= '0;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (key_q == '0) begin
                        state_q      <= ST_IDLE;
                        key_active_q <= 1'b0;
                    end else if (key_q != held_q) begin
                        state_q      <= ST_PRESS;
                        held_q       <= key_q;
                        key_active_q <= key_mapped(key_q);
                    end else if (frame_start) begin
                        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wc_re_q  <= W'(C_RE_DEF);
            wc_im_q  <= W'(C_IM_DEF);
            wpan_x_q <= '0;
            wpan_y_q <= '0;
            wzoom_q  <= '0;
        end else if (step) begin
            case (held_q)
                KEY_RIGHT, KEY_LEFT: wc_re_q  <= wc_re_d;
                KEY_UP,    KEY_DOWN: wc_im_q  <= wc_im_d;
                KEY_D,     KEY_A:    wpan_x_q <= wpan_x_d;
                KEY_W,     KEY_S:    wpan_y_q <= wpan_y_d;
                KEY_Q: if (wzoom_q < ZOOM_MAX_W) wzoom_q <= wzoom_q + 1'b1;
                KEY_E: if (wzoom_q != '0)        wzoom_q <= wzoom_q - 1'b1;
                KEY_R: begin
                    wc_re_q  <= W'(C_RE_DEF);
                    wc_im_q  <= W'(C_IM_DEF);
                    wpan_x_q <= '0;
                    wpan_y_q <= '0;
                    wzoom_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Published snapshot stays frozen while valid; reset forces a reload of defaults.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pc_re_q  <= W'(C_RE_DEF);
            pc_im_q  <= W'(C_IM_DEF);
            ppan_x_q <= '0;
            ppan_y_q <= '0;
            pzoom_q  <= '0;
            valid_q  <= 1'b1;
        end else if (valid_q) begin
            if (param_ack) valid_q <= 1'b0;
        end else if ({wc_re_q, wc_im_q, wpan_x_q, wpan_y_q, wzoom_q} !=
                     {pc_re_q, pc_im_q, ppan_x_q, ppan_y_q, pzoom_q}) begin
            pc_re_q  <= wc_re_q;
            pc_im_q  <= wc_im_q;
            ppan_x_q <= wpan_x_q;
            ppan_y_q <= wpan_y_q;
            pzoom_q  <= wzoom_q;
            valid_q  <= 1'b1;
        end
    end

    assign c_re        = pc_re_q;
    assign c_im        = pc_im_q;
    assign pan_x       = ppan_x_q;
    assign pan_y       = ppan_y_q;
    assign zoom        = pzoom_q;
    assign param_valid = valid_q;
    assign key_active  = key_active_q;

endmodule

// File: tb/tb_jsv_key_param_ctrl.sv
// Directed bench for jsv_key_param_ctrl: press/repeat, saturation, zoom-scaled pan,
// frozen snapshot handshake, direct key switch and asynchronous reset.
module tb_jsv_key_param_ctrl;

    logic               clk_clk = 1'b0;
    logic               reset_reset_n;
    logic [7:0]         keycode;
    logic               frame_start;
    logic               param_ack;
    logic signed [15:0] c_re, c_im, pan_x, pan_y;
    logic [3:0]         zoom;
    logic               param_valid, key_active;

    int n_assert = 0;
    int n_fail   = 0;

    jsv_key_param_ctrl dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .keycode      (keycode),
        .frame_start  (frame_start),
        .c_re         (c_re),
        .c_im         (c_im),
        .pan_x        (pan_x),
        .pan_y        (pan_y),
        .zoom         (zoom),
        .param_valid  (param_valid),
        .param_ack    (param_ack),
        .key_active   (key_active)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_ack();
        param_ack = 1'b1;
        tick(1);
        param_ack = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        tick(3);
        keycode = 8'h00;
        tick(2);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
    endtask

    // Drain any pending snapshot so the outputs mirror the working registers.
    task automatic flush();
        param_ack = 1'b0;
        tick(3);
        repeat (3) begin
            if (param_valid) begin
                do_ack();
                tick(2);
            end
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        keycode       = 8'h00;
        frame_start   = 1'b0;
        param_ack     = 1'b0;
        tick(2);
        chk("rst_valid", {15'd0, param_valid}, 16'h0001);
        reset_reset_n = 1'b1;
        tick(1);
        chk("def_valid", {15'd0, param_valid}, 16'h0001);
        chk("def_c_re", c_re, 16'hF334);
        chk("def_c_im", c_im, 16'h027F);
        chk("def_pan_x", pan_x, 16'h0000);
        chk("def_pan_y", pan_y, 16'h0000);
        chk("def_zoom", {12'd0, zoom}, 16'h0000);
        chk("def_active", {15'd0, key_active}, 16'h0000);
        do_ack();
        chk("ack_clr", {15'd0, param_valid}, 16'h0000);
        tick(2);
        chk("no_repub", {15'd0, param_valid}, 16'h0000);

        // Right held: press step, then repeats at frames 4 and 8.
        keycode = 8'h4F;
        tick(3);
        chk("lat3_valid", {15'd0, param_valid}, 16'h0000);
        tick(1);
        chk("lat4_valid", {15'd0, param_valid}, 16'h0001);
        chk("press_c_re", c_re, 16'hF344);
        chk("hold_active", {15'd0, key_active}, 16'h0001);
        do_ack();
        repeat (4) frame();
        chk("rep1_c_re", c_re, 16'hF354);
        chk("rep1_valid", {15'd0, param_valid}, 16'h0001);
        do_ack();
        repeat (4) frame();
        chk("rep2_c_re", c_re, 16'hF364);
        do_ack();
        frame();
        chk("f9_valid", {15'd0, param_valid}, 16'h0000);
        chk("f9_c_re", c_re, 16'hF364);
        keycode = 8'h00;
        tick(3);
        chk("rel_active", {15'd0, key_active}, 16'h0000);

        // Up held with a frame every cycle until far past the +2.0 clamp.
        keycode     = 8'h52;
        param_ack   = 1'b1;
        frame_start = 1'b1;
        tick(2200);
        frame_start = 1'b0;
        keycode     = 8'h00;
        flush();
        chk("c_im_sat", c_im, 16'h2000);
        chk("c_re_kept", c_re, 16'hF364);
        chk("sat_valid", {15'd0, param_valid}, 16'h0000);

        param_ack = 1'b1;
        repeat (12) press(8'h14);
        flush();
        chk("zoom_max", {12'd0, zoom}, 16'h000A);

        press(8'h07);
        flush();
        chk("pan_z10", pan_x, 16'h0001);
        param_ack = 1'b1;
        repeat (8) press(8'h08);
        flush();
        chk("zoom_2", {12'd0, zoom}, 16'h0002);
        press(8'h07);
        flush();
        chk("pan_z2", pan_x, 16'h0101);

        // Three Left presses with no ack: only the first reaches the outputs.
        repeat (3) press(8'h50);
        chk("frozen_c_re", c_re, 16'hF354);
        chk("frozen_valid", {15'd0, param_valid}, 16'h0001);
        do_ack();
        tick(1);
        chk("accum_valid", {15'd0, param_valid}, 16'h0001);
        chk("accum_c_re", c_re, 16'hF334);
        do_ack();

        // Step lands in the same cycle as the ack of a pending snapshot.
        press(8'h50);
        chk("pend_c_re", c_re, 16'hF324);
        keycode = 8'h4F;
        tick(2);
        param_ack = 1'b1;
        tick(1);
        param_ack = 1'b0;
        tick(1);
        chk("same_valid", {15'd0, param_valid}, 16'h0001);
        chk("same_c_re", c_re, 16'hF334);
        do_ack();
        keycode = 8'h00;
        flush();

        // Up straight to W: the new key steps without a release in between.
        keycode = 8'h52;
        tick(3);
        keycode = 8'h1A;
        tick(4);
        chk("switch_pan_y", pan_y, 16'h0100);
        chk("switch_valid", {15'd0, param_valid}, 16'h0001);
        chk("switch_active", {15'd0, key_active}, 16'h0001);
        chk("switch_c_im", c_im, 16'h2000);

        reset_reset_n = 1'b0;
        #2;
        chk("arst_valid", {15'd0, param_valid}, 16'h0001);
        chk("arst_c_re", c_re, 16'hF334);
        chk("arst_c_im", c_im, 16'h027F);
        chk("arst_pan_x", pan_x, 16'h0000);
        chk("arst_pan_y", pan_y, 16'h0000);
        chk("arst_zoom", {12'd0, zoom}, 16'h0000);
        chk("arst_active", {15'd0, key_active}, 16'h0000);
        keycode = 8'h00;
        tick(2);
        reset_reset_n = 1'b1;
        tick(3);
        chk("post_active", {15'd0, key_active}, 16'h0000);
        chk("post_valid", {15'd0, param_valid}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
